// File: rtl/defines_pkg.sv
// Shared bank-select type and bank constants for the ping-pong buffer.
package defines_pkg;

  typedef logic bank_sel_t;

  localparam bank_sel_t BANK_A = 1'b0;
  localparam bank_sel_t BANK_B = 1'b1;

endpackage

// File: rtl/dbuf_ram.sv
// Two-bank storage: one write port, one registered read port, address {bank, addr}.
// rdata holds its value on cycles without a read.
module dbuf_ram
  import defines_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  bank_sel_t        wbank,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  bank_sel_t        rbank,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int WORDS = 2 * (2 ** AW);

  logic [WIDTH-1:0] mem [WORDS];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, waddr}] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[{rbank, raddr}];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dbuf_toggle_bank.sv
// Ping-pong buffer steered by schedule toggle pulses; producer fills one bank
// while the consumer drains the other. Define DBUF_ERR_FLAGS_EN for overrun/underrun flags.
module dbuf_toggle_bank
  import defines_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_toggle,
  input  logic             rd_toggle,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             wr_bank,
  output logic             rd_bank,
  output logic [1:0]       bank_valid,
  input  logic             clr_err,
  output logic             overrun,
  output logic             underrun
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  bank_sel_t         wr_bank_q, wr_bank_d;
  bank_sel_t         rd_bank_q, rd_bank_d;
  logic [1:0]        bank_valid_q, bank_valid_d;
  logic [AW:0]       wr_addr_q, wr_addr_d;
  logic [AW:0]       rd_addr_q, rd_addr_d;
  logic [1:0][AW:0]  count_q, count_d;
  logic              rd_valid_q;
  logic              wr_ok, rd_ok;

  always_comb begin
    wr_ok = wr_en && (wr_addr_q < DEPTH_C);
    rd_ok = rd_en && bank_valid_q[rd_bank_q] && (rd_addr_q < count_q[rd_bank_q]);

    wr_addr_d    = wr_addr_q + {{AW{1'b0}}, wr_ok};
    rd_addr_d    = rd_addr_q + {{AW{1'b0}}, rd_ok};
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    count_d      = count_q;
    bank_valid_d = bank_valid_q;

    // Release before commit so a commit into the same bank leaves it valid.
    if (rd_toggle) begin
      bank_valid_d[rd_bank_q] = 1'b0;
      rd_bank_d               = ~rd_bank_q;
      rd_addr_d               = '0;
    end
    if (wr_toggle) begin
      count_d[wr_bank_q]      = wr_addr_d;
      bank_valid_d[wr_bank_q] = 1'b1;
      wr_bank_d               = ~wr_bank_q;
      wr_addr_d               = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q    <= BANK_A;
      rd_bank_q    <= BANK_B;
      bank_valid_q <= 2'b00;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      bank_valid_q <= bank_valid_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      count_q      <= count_d;
      rd_valid_q   <= rd_ok;
    end
  end

`ifdef DBUF_ERR_FLAGS_EN
  logic      overrun_q, overrun_d;
  logic      underrun_q, underrun_d;
  logic      ov_set, un_set;
  bank_sel_t wr_enter, rd_enter;

  // A same-cycle release/commit on the other side satisfies the swap check.
  always_comb begin
    wr_enter   = ~wr_bank_q;
    rd_enter   = ~rd_bank_q;
    ov_set     = (wr_en && !wr_ok)
               || (wr_toggle && bank_valid_q[wr_enter]
                   && !(rd_toggle && (rd_bank_q == wr_enter)));
    un_set     = (rd_en && !rd_ok)
               || (rd_toggle && !bank_valid_q[rd_enter]
                   && !(wr_toggle && (wr_bank_q == rd_enter)));
    overrun_d  = ov_set || (overrun_q && !clr_err);
    underrun_d = un_set || (underrun_q && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign overrun  = overrun_q;
  assign underrun = underrun_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overrun        = 1'b0;
  assign underrun       = 1'b0;
`endif

  dbuf_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .wbank (wr_bank_q),
    .waddr (wr_addr_q[AW-1:0]),
    .wdata (wr_data),
    .re    (rd_ok),
    .rbank (rd_bank_q),
    .raddr (rd_addr_q[AW-1:0]),
    .rdata (rd_data)
  );

  assign rd_valid   = rd_valid_q;
  assign wr_bank    = wr_bank_q;
  assign rd_bank    = rd_bank_q;
  assign bank_valid = bank_valid_q;

endmodule

// File: tb/tb_dbuf_toggle_bank.sv
// Directed bench for dbuf_toggle_bank: read data scoreboarded by a negedge monitor,
// pointer/flag state checked after each step.
module tb_dbuf_toggle_bank;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
`ifdef DBUF_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_toggle = 1'b0, rd_toggle = 1'b0;
  logic             wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, wr_bank, rd_bank, overrun, underrun;
  logic [1:0]       bank_valid;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q [$];

  dbuf_toggle_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_toggle(wr_toggle), .rd_toggle(rd_toggle),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .bank_valid(bank_valid), .clr_err(clr_err), .overrun(overrun),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid must match the oldest expected word.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rd_valid=1 data 0x%0h expected no read", rd_data);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en = 0; rd_en = 0; wr_toggle = 0; rd_toggle = 0; clr_err = 0;
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    wr_en = 1; wr_data = d;
    tick();
  endtask

  task automatic rd(input bit ok, input logic [WIDTH-1:0] d);
    rd_en = 1;
    if (ok) exp_q.push_back(d);
    tick();
  endtask

  task automatic swap_both();
    wr_toggle = 1; rd_toggle = 1;
    tick();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
    chk({tag, "_rd_bank"}, 32'(rd_bank), 32'd1);
    chk({tag, "_bank_valid"}, 32'(bank_valid), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    rst = 1;
    tick(); tick();
    rst = 0;
    check_reset("reset");

    // Fill bank A, swap both sides, drain in order.
    for (int i = 1; i <= 8; i++) wr(16'(i));
    swap_both();
    chk("fill_wr_bank", 32'(wr_bank), 32'd1);
    chk("fill_rd_bank", 32'(rd_bank), 32'd0);
    chk("fill_bank_valid", 32'(bank_valid), 32'b01);
    for (int i = 1; i <= 8; i++) rd(1'b1, 16'(i));
    chk("fill_overrun", 32'(overrun), 32'd0);
    chk("fill_underrun", 32'(underrun), 32'd0);

    // Partial bank: 3 words into bank B, 5 reads, 4th and 5th rejected.
    wr(16'h0011); wr(16'h0022); wr(16'h0033);
    swap_both();
    chk("part_bank_valid", 32'(bank_valid), 32'b10);
    chk("part_rd_bank", 32'(rd_bank), 32'd1);
    rd(1'b1, 16'h0011); rd(1'b1, 16'h0022); rd(1'b1, 16'h0033);
    chk("part_underrun_pre", 32'(underrun), 32'd0);
    rd(1'b0, '0);
    chk("part_underrun_4th", 32'(underrun), 32'(ERR_EN));
    rd(1'b0, '0);
    clr_err = 1; tick();
    chk("part_underrun_clr", 32'(underrun), 32'd0);

    // Write overflow: 9th word dropped, commit count is 8.
    for (int i = 1; i <= 8; i++) wr(16'h0100 + 16'(i));
    chk("ovf_overrun_pre", 32'(overrun), 32'd0);
    wr(16'h0109);
    chk("ovf_overrun", 32'(overrun), 32'(ERR_EN));
    swap_both();
    chk("ovf_bank_valid", 32'(bank_valid), 32'b01);
    for (int i = 1; i <= 8; i++) rd(1'b1, 16'h0100 + 16'(i));
    rd(1'b0, '0);
    chk("ovf_underrun_9th", 32'(underrun), 32'(ERR_EN));
    clr_err = 1; tick();
    chk("ovf_clr_overrun", 32'(overrun), 32'd0);
    chk("ovf_clr_underrun", 32'(underrun), 32'd0);

    // Overrun on swap: wr_bank=1, rd_bank=0, bank A still valid.
    wr_toggle = 1; tick();
    chk("swap_overrun", 32'(overrun), 32'(ERR_EN));
    chk("swap_bank_valid", 32'(bank_valid), 32'b11);
    chk("swap_wr_bank", 32'(wr_bank), 32'd0);
    clr_err = 1; tick();
    chk("swap_clr", 32'(overrun), 32'd0);
    wr_toggle = 1; clr_err = 1; tick();
    chk("swap_clr_coincident", 32'(overrun), 32'(ERR_EN));

    rst = 1; tick(); rst = 0;
    check_reset("reset2");

    // Same-cycle write + toggle: the 8th word lands in the committed bank.
    for (int i = 1; i <= 7; i++) wr(16'h0A00 + 16'(i));
    wr_en = 1; wr_data = 16'hABCD;
    swap_both();
    for (int i = 1; i <= 7; i++) rd(1'b1, 16'h0A00 + 16'(i));
    rd(1'b1, 16'hABCD);
    chk("wt_underrun", 32'(underrun), 32'd0);
    chk("wt_overrun", 32'(overrun), 32'd0);

    // Reset in the middle of a drain.
    for (int i = 1; i <= 4; i++) wr(16'h0C00 + 16'(i));
    swap_both();
    chk("mid_bank_valid", 32'(bank_valid), 32'b10);
    rd(1'b1, 16'h0C01);
    rd(1'b1, 16'h0C02);
    rst = 1; rd_en = 1; tick(); rst = 0;
    check_reset("mid_reset");

    tick(); tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbuf_toggle_bank.md
# dbuf_toggle_bank

Ping-pong (double) buffer that sits on a dataflow edge between a producer and a consumer actor and is steered by the schedule controller's per-buffer `buff_wr_toggle`/`buff_rd_toggle` pulses. The producer fills one bank while the consumer drains the other. Each toggle pulse commits or releases a bank and swaps the side being accessed. One instance exists per scheduled buffer.

## Interface
- `WIDTH`, 16, data word width
- `DEPTH`, 8, words per bank (≥2)
- `AW`, `$clog2(DEPTH)`, bank address width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wr_toggle`  in  1  commit current write bank, swap write side
- `rd_toggle`  in  1  release current read bank, swap read side
- `wr_en`  in  1  write `wr_data` at current write address
- `wr_data`  in  WIDTH  write word
- `rd_en`  in  1  read word at current read address
- `rd_data`  out  WIDTH  read word
- `rd_valid`  out  1  `rd_data` valid strobe
- `wr_bank`  out  1  bank currently written
- `rd_bank`  out  1  bank currently read
- `bank_valid`  out  2  per-bank committed-and-unconsumed flag
- `clr_err`  in  1  clear sticky error flags
- `overrun`  out  1  sticky: write-side error
- `underrun`  out  1  sticky: read-side error

## Operation
- Reset values: `wr_bank`=0, `rd_bank`=1, `bank_valid`=2'b00, `wr_addr`=0, `rd_addr`=0, both `count[b]`=0, `rd_data`=0, `rd_valid`=0, `overrun`=0, `underrun`=0.
- Write:
  - `wr_en` with `wr_addr`<DEPTH stores into bank `wr_bank`, then `wr_addr`++ (width AW+1).
  - `wr_en` with `wr_addr`==DEPTH drops the word and sets `overrun`.
- `wr_toggle`:
  - `count[wr_bank]`←`wr_addr` (including a write in the same cycle).
  - `bank_valid[wr_bank]`←1.
  - `wr_bank`←~`wr_bank`, `wr_addr`←0.
  - If the bank being entered is still valid and is not released this cycle, set `overrun`. The swap still happens and the bank is overwritten.
- Read:
  - `rd_en` with `rd_addr`<`count[rd_bank]` and `bank_valid[rd_bank]`=1 reads the word, then `rd_addr`++.
  - Otherwise `rd_en` sets `underrun`, leaves `rd_addr` unchanged, and `rd_valid` stays 0.
- `rd_toggle`:
  - `bank_valid[rd_bank]`←0.
  - `rd_bank`←~`rd_bank`, `rd_addr`←0.
  - If the bank being entered is not valid and is not committed this cycle, set `underrun`. The swap still happens.
- Simultaneous events:
  - Access plus toggle on the same side: the access uses the pre-toggle bank and address; the swap follows.
  - `wr_toggle`+`rd_toggle` together: both commits/releases apply. A same-cycle release satisfies the overrun check, and a same-cycle commit satisfies the underrun check.
- `clr_err` clears both sticky flags. A new error in the same cycle wins, so the flag stays 1.
- `rst` mid-operation discards all contents and state. No partial flush.

## Timing
- `rd_data`/`rd_valid` are registered, with 1-cycle latency after an accepted `rd_en`. `rd_data` holds its last value when `rd_valid`=0.
- Write data is readable from the cycle after the commit `wr_toggle`.
- Flags, bank pointers, and `bank_valid` update on the clock edge of the causing event and are visible the next cycle.
- There is no back-pressure. Correct operation relies on the schedule, and the error flags are diagnostic only.

## Configuration
- `DBUF_ERR_FLAGS_EN` defined:
  - overrun/underrun detection and `clr_err` are active as above.
  - Dropped writes and rejected reads still occur.
- Undefined:
  - detection logic is removed, `overrun`/`underrun` tie to 0, and `clr_err` is ignored.
  - Data-path behaviour is identical.

## Structure
- `defines_pkg` holds:
  - `typedef logic bank_sel_t`
  - `localparam bank_sel_t BANK_A = 1'b0, BANK_B = 1'b1`
- Sub-module `dbuf_ram`: single-clock, one write port and one registered read port, `WIDTH`×(2·`DEPTH`). The address is {bank, addr}.
- Pointer, count, and flag logic live in the top module.

## Test plan
- **Fill/drain:** write 8 words 0x0001..0x0008, then `wr_toggle`+`rd_toggle` together, then 8 `rd_en` → 0x0001..0x0008 in order, each 1 cycle after `rd_en`; no errors.
- **Partial bank:** write 3 words then commit; after the swap, 5 `rd_en` → 3 valid reads, `underrun`=1 on the 4th read, `rd_addr` holds at 3.
- **Write overflow:** 9 `wr_en` before the toggle → 9th word dropped, `overrun`=1, `count`=8.
- **Overrun on swap:** two `wr_toggle` with no `rd_toggle` → second sets `overrun`; `clr_err` → 0; `clr_err` with a coincident error → stays 1.
- **Same-cycle write+toggle:** `wr_en`(0xABCD) with `wr_toggle` → the word lands at the old bank's last slot and the count includes it.
- **Reset mid-read:** `rst` during a drain → next cycle all outputs at their reset values; `bank_valid`=00.
